alu_arbiter: RTL and testbench

//  Shares the single ALU instance between N_REQ requesters using round-robin arbitration.

---
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bundle for alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters, consumer and ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 2,
    parameter int IDW   = 3
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*4-1:0]     req_ctrl;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic [3:0]             alu_ctrl;
    logic [WIDTH-1:0]       alu_result;
    logic                   alu_zero;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_zero;
    logic                   rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_ctrl, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ requesters,
// with a one-entry registered response slot tagged by requester index.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 2,
    parameter int IDW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [PTRW-1:0]  r_rrLast;
    logic [PTRW-1:0]  w_winner;
    logic [PTRW-1:0]  w_cand;
    logic             w_anyValid;
    logic             w_slotFree;
    logic             w_accept;
    logic             w_ctrlLegal;
    logic [3:0]       w_winCtrl;
    logic [IDW-1:0]   r_rspId;
    logic [WIDTH-1:0] r_rspResult;
    logic             r_rspZero;
    logic             r_rspErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_anyValid = 1'b0;
        w_winner   = '0;
        w_cand     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = PTRW'((int'(r_rrLast) + i) % N_REQ);
            if (!w_anyValid && bus.req_valid[w_cand]) begin
                w_anyValid = 1'b1;
                w_winner   = w_cand;
            end
        end
    end

    always_comb begin
        w_slotFree = (r_state == EMPTY) || bus.rsp_ready;
        w_accept   = w_anyValid && w_slotFree;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_nextState = FULL;
            FULL:    if (!w_accept && bus.rsp_ready) w_nextState = EMPTY;
            default: w_nextState = EMPTY;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_ctrl  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_anyValid && (w_winner == PTRW'(k))) begin
                bus.req_ready[k] = w_accept;
                bus.alu_a        = bus.req_a[k*WIDTH +: WIDTH];
                bus.alu_b        = bus.req_b[k*WIDTH +: WIDTH];
                bus.alu_ctrl     = bus.req_ctrl[k*4 +: 4];
            end
        end
        bus.rsp_valid  = (r_state == FULL);
        bus.rsp_id     = r_rspId;
        bus.rsp_result = r_rspResult;
        bus.rsp_zero   = r_rspZero;
        bus.rsp_err    = r_rspErr;
    end

    always_comb begin
        w_winCtrl   = bus.alu_ctrl;
        w_ctrlLegal = w_winCtrl inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    end

    // An illegal code reports result 0 / zero 1 regardless of what the ALU produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rspId     <= '0;
            r_rspResult <= '0;
            r_rspZero   <= 1'b0;
            r_rspErr    <= 1'b0;
            r_rrLast    <= PTRW'(N_REQ - 1);
        end else if (w_accept) begin
            r_rspId     <= IDW'(w_winner);
            r_rspErr    <= !w_ctrlLegal;
            r_rspResult <= w_ctrlLegal ? bus.alu_result : '0;
            r_rspZero   <= w_ctrlLegal ? bus.alu_zero : 1'b1;
            r_rrLast    <= w_winner;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then randomized traffic,
// all compared against a transaction-level reference model of the arbiter.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH), .N_REQ(NREQ), .IDW(IDW)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .N_REQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectorCount = 0;
    int missCount   = 0;

    logic [31:0] reqA [NREQ];
    logic [31:0] reqB [NREQ];
    logic [3:0]  reqCtrl [NREQ];
    logic [3:0]  legalCodes [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

    bit          mFull;
    int          mId;
    int          mLast;
    logic [31:0] mResult;
    bit          mZero;
    bit          mErr;

    // Stand-in ALU; illegal codes give a poison value the arbiter must discard.
    function automatic logic [31:0] aluRef(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign bus.alu_result = aluRef(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mFull   = 0;
        mId     = 0;
        mResult = '0;
        mZero   = 0;
        mErr    = 0;
        mLast   = NREQ - 1;
    endtask

    // One cycle: drive at negedge, check mid-cycle, then advance the model past the coming edge.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input bit rdy, output int accepted);
        int               w;
        bit               free;
        logic [NREQ-1:0]  expReady;
        logic [31:0]      expA;
        logic [31:0]      expB;
        logic [3:0]       expCtrl;
        @(negedge clk);
        bus.req_valid = valid;
        bus.rsp_ready = rdy;
        for (int k = 0; k < NREQ; k++) begin
            bus.req_a[k*WIDTH +: WIDTH] = reqA[k];
            bus.req_b[k*WIDTH +: WIDTH] = reqB[k];
            bus.req_ctrl[k*4 +: 4]      = reqCtrl[k];
        end
        #1;
        checkOutput("rspValid", bus.rsp_valid, mFull);
        checkOutput("rspId", bus.rsp_id, mId);
        checkOutput("rspResult", bus.rsp_result, mResult);
        checkOutput("rspZero", bus.rsp_zero, mZero);
        checkOutput("rspErr", bus.rsp_err, mErr);
        w = -1;
        for (int i = 1; i <= NREQ; i++) begin
            if (w < 0 && valid[(mLast + i) % NREQ]) w = (mLast + i) % NREQ;
        end
        free     = !mFull || rdy;
        expReady = '0;
        accepted = -1;
        expA     = '0;
        expB     = '0;
        expCtrl  = '0;
        if (w >= 0) begin
            expA    = reqA[w];
            expB    = reqB[w];
            expCtrl = reqCtrl[w];
            if (free) begin
                expReady[w] = 1'b1;
                accepted    = w;
            end
        end
        checkOutput("reqReady", bus.req_ready, expReady);
        checkOutput("aluA", bus.alu_a, expA);
        checkOutput("aluB", bus.alu_b, expB);
        checkOutput("aluCtrl", bus.alu_ctrl, expCtrl);
        if (accepted >= 0) begin
            mFull = 1;
            mId   = w;
            mLast = w;
            if (reqCtrl[w] inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12}) begin
                mErr    = 0;
                mResult = aluRef(reqCtrl[w], reqA[w], reqB[w]);
                mZero   = (mResult == 32'd0);
            end else begin
                mErr    = 1;
                mResult = '0;
                mZero   = 1;
            end
        end else if (mFull && rdy) begin
            mFull = 0;
        end
    endtask

    initial begin
        int              acc;
        logic [NREQ-1:0] pend;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            reqA[k]    = '0;
            reqB[k]    = '0;
            reqCtrl[k] = '0;
        end
        modelReset();

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetValid", bus.rsp_valid, 0);
        checkOutput("resetId", bus.rsp_id, 0);
        checkOutput("resetResult", bus.rsp_result, 0);
        checkOutput("resetZero", bus.rsp_zero, 0);
        checkOutput("resetErr", bus.rsp_err, 0);
        checkOutput("resetReady", bus.req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add from requester 0, one-cycle latency
        reqA[0] = 32'd5; reqB[0] = 32'd3; reqCtrl[0] = 4'd2;
        applyStimulus(4'b0001, 1'b1, acc);
        checkOutput("t1Ready", bus.req_ready, 4'b0001);
        applyStimulus(4'b0000, 1'b1, acc);
        checkOutput("t1Valid", bus.rsp_valid, 1);
        checkOutput("t1Id", bus.rsp_id, 0);
        checkOutput("t1Result", bus.rsp_result, 8);

        // Two requesters back-to-back alternate grants
        reqA[0] = 32'd10; reqB[0] = 32'd4; reqCtrl[0] = 4'd6;
        reqA[1] = 32'd7;  reqB[1] = 32'd7; reqCtrl[1] = 4'd6;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0011, 1'b1, acc);
            checkOutput("t2Grant", acc, (i % 2 == 0) ? 1 : 0);
        end

        // Backpressure freezes the slot, then the other requester wins
        applyStimulus(4'b0011, 1'b1, acc);
        checkOutput("t3First", acc, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0011, 1'b0, acc);
            checkOutput("t3Stall", bus.req_ready, 0);
        end
        applyStimulus(4'b0011, 1'b1, acc);
        checkOutput("t3Other", acc, 0);

        // Zero flag on equal subtract, and illegal control code
        reqA[1] = 32'h1234; reqB[1] = 32'h1234; reqCtrl[1] = 4'd6;
        applyStimulus(4'b0010, 1'b1, acc);
        applyStimulus(4'b0000, 1'b1, acc);
        checkOutput("t4SubResult", bus.rsp_result, 0);
        checkOutput("t4SubZero", bus.rsp_zero, 1);
        checkOutput("t4SubErr", bus.rsp_err, 0);
        reqCtrl[0] = 4'd9;
        applyStimulus(4'b0001, 1'b1, acc);
        applyStimulus(4'b0000, 1'b1, acc);
        checkOutput("t4BadErr", bus.rsp_err, 1);
        checkOutput("t4BadResult", bus.rsp_result, 0);
        checkOutput("t4BadZero", bus.rsp_zero, 1);

        // Asynchronous reset while full
        reqCtrl[0] = 4'd2;
        applyStimulus(4'b0011, 1'b0, acc);
        applyStimulus(4'b0000, 1'b0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5AsyncValid", bus.rsp_valid, 0);
        checkOutput("t5AsyncId", bus.rsp_id, 0);
        checkOutput("t5AsyncResult", bus.rsp_result, 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0011, 1'b1, acc);
        checkOutput("t5Req0Wins", acc, 0);

        // Sparse requesters 1 and 3 after requester 1 was last served
        reqA[3] = 32'h0F0F; reqB[3] = 32'h00FF; reqCtrl[3] = 4'd0;
        applyStimulus(4'b0010, 1'b1, acc);
        checkOutput("t6Setup", acc, 1);
        applyStimulus(4'b1010, 1'b1, acc);
        checkOutput("t6Grant3", bus.req_ready, 4'b1000);
        applyStimulus(4'b1010, 1'b1, acc);
        checkOutput("t6Grant1", bus.req_ready, 4'b0010);
        applyStimulus(4'b0000, 1'b1, acc);

        // Random traffic; a pending request is held stable until accepted
        pend = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(1, 0) == 1) begin
                    pend[k]    = 1'b1;
                    reqA[k]    = $urandom;
                    reqB[k]    = ($urandom_range(3, 0) == 0) ? reqA[k] : $urandom;
                    reqCtrl[k] = ($urandom_range(7, 0) == 0) ? 4'($urandom) : legalCodes[$urandom_range(5, 0)];
                end
            end
            applyStimulus(pend, ($urandom_range(3, 0) != 0), acc);
            if (acc >= 0) pend[acc] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
